// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared definitions for the PRBS10 (x^10 + x^3 + 1) checker:
//   - prbs_state_t : checker state (SEED, VERIFY, LOCKED)
//   - PRBS_LEN, TAP_A, TAP_B, PRBS_PERIOD : sequence geometry
//   - prbs_predict() : next expected bit from a 10-bit history (h[0] newest)
package prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    localparam int PRBS_LEN    = 10;
    localparam int TAP_A       = 7;
    localparam int TAP_B       = 10;
    localparam int PRBS_PERIOD = 1023;

    // x[n] = x[n-7] ^ x[n-10]; with h[0] the newest bit, x[n-k] sits in h[k-1].
    function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] h);
        return h[TAP_A-1] ^ h[TAP_B-1];
    endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter
// CNT_W-wide up counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset (count -> 0)
//   inc   in  increment enable
//   count out current count
module prbs_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
// Receive-side checker for the PRBS10 (x^10 + x^3 + 1) stream. Collects ten
// seed bits, self-synchronises until LOCK_CNT consecutive predictions match,
// then runs the history as a flywheel and flags every deviating bit.
// Optional macro PRBS_CHK_ERRCNT_EN: when defined, err_count and bit_count
// are implemented; otherwise both outputs are tied to 0.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   in_bit    in  received stream bit
//   in_valid  in  in_bit is sampled on this edge when high
//   locked    out checker synchronised to the sequence
//   err_pulse out one-cycle pulse: last valid bit mismatched while locked
//   err_count out saturating mismatch count while locked
//   bit_count out saturating count of valid bits checked while locked
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 20,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    prbs_state_t         state_q, state_d;
    logic [PRBS_LEN-1:0] h_q, h_d;
    logic [3:0]          seed_q, seed_d;
    logic [7:0]          match_q, match_d;
    logic [3:0]          loss_q, loss_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic                pred;
    logic                mismatch;
    logic [PRBS_LEN-1:0] h_rx;     // history with the received bit shifted in
    logic [PRBS_LEN-1:0] h_fly;    // history with the predicted bit shifted in

    assign pred     = prbs_predict(h_q);
    assign mismatch = in_bit ^ pred;
    assign h_rx     = {h_q[PRBS_LEN-2:0], in_bit};
    assign h_fly    = {h_q[PRBS_LEN-2:0], pred};

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        seed_d   = seed_q;
        match_d  = match_q;
        loss_d   = loss_q;
        locked_d = locked_q;
        err_d    = 1'b0;

        if (in_valid) begin
            case (state_q)
                SEED: begin
                    h_d = h_rx;
                    if (seed_q == 4'(PRBS_LEN - 1)) begin
                        seed_d = '0;
                        // An all-zero history is the LFSR lock-up state; keep seeding.
                        if (h_rx != '0) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        seed_d = seed_q + 4'd1;
                    end
                end

                VERIFY: begin
                    h_d = h_rx;
                    if (!mismatch) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 == 8'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            loss_d   = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end

                LOCKED: begin
                    // Flywheel: a corrupted bit never enters the history, so it
                    // is reported once and does not poison later predictions.
                    h_d = h_fly;
                    if (mismatch) begin
                        err_d  = 1'b1;
                        loss_d = loss_q + 4'd1;
                        if (loss_q + 4'd1 == 4'(LOSS_CNT)) begin
                            state_d  = SEED;
                            seed_d   = '0;
                            match_d  = '0;
                            locked_d = 1'b0;
                        end
                    end else begin
                        loss_d = '0;
                    end
                end

                default: begin
                    state_d  = SEED;
                    seed_d   = '0;
                    match_d  = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEED;
            h_q      <= '0;
            seed_q   <= '0;
            match_q  <= '0;
            loss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            seed_q   <= seed_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_q;

`ifdef PRBS_CHK_ERRCNT_EN
    logic bit_inc;
    logic err_inc;

    assign bit_inc = in_valid && (state_q == LOCKED);
    assign err_inc = bit_inc && mismatch;

    prbs_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (err_count)
    );

    prbs_sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bit_inc),
        .count (bit_count)
    );
`else
    assign err_count = '0;
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    localparam int LOCK  = 20;
    localparam int LOSS  = 4;
    localparam int CW    = 16;
`ifdef PRBS_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] bit_count;

    int n_checks = 0;
    int n_errors = 0;

    prbs_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: act=%0d req=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint ecnt(input longint v);
        return CNT_EN ? v : 0;
    endfunction

    // ---------------- stimulus source: PRBS10 generator, reset seed 1 --------
    bit srcq[$];   // oldest first, newest last

    task automatic src_reset();
        srcq = {};
        for (int i = 0; i < 9; i++) srcq.push_back(1'b0);
        srcq.push_back(1'b1);
    endtask

    task automatic src_next(output logic b);
        b = srcq[3] ^ srcq[0];   // x[n-7] ^ x[n-10]
        void'(srcq.pop_front());
        srcq.push_back(b);
    endtask

    // ---------------- behavioural reference model ----------------------------
    // mode: 0 = collecting seed, 1 = verifying, 2 = locked
    int     m_mode;
    bit     m_hist[$];   // last ten bits, oldest first
    int     m_nseed, m_nmatch, m_nloss;
    bit     m_locked, m_errp;
    longint m_errc, m_bitc;
    longint CMAX = (longint'(1) << CW) - 1;

    task automatic m_reset();
        m_mode = 0; m_nseed = 0; m_nmatch = 0; m_nloss = 0;
        m_locked = 0; m_errp = 0; m_errc = 0; m_bitc = 0;
        m_hist = {};
        for (int i = 0; i < 10; i++) m_hist.push_back(1'b0);
    endtask

    task automatic m_step(input bit b);
        bit p;
        int ones;
        p = m_hist[3] ^ m_hist[0];
        m_errp = 0;
        if (m_mode == 0) begin
            void'(m_hist.pop_front()); m_hist.push_back(b);
            m_nseed++;
            if (m_nseed == 10) begin
                m_nseed = 0;
                ones = 0;
                foreach (m_hist[i]) ones += m_hist[i];
                if (ones > 0) begin m_mode = 1; m_nmatch = 0; end
            end
        end else if (m_mode == 1) begin
            void'(m_hist.pop_front()); m_hist.push_back(b);
            if (b == p) m_nmatch++; else m_nmatch = 0;
            if (m_nmatch == LOCK) begin m_mode = 2; m_locked = 1; m_nloss = 0; end
        end else begin
            void'(m_hist.pop_front()); m_hist.push_back(p);
            if (m_bitc < CMAX) m_bitc++;
            if (b != p) begin
                m_errp = 1;
                if (m_errc < CMAX) m_errc++;
                m_nloss++;
                if (m_nloss == LOSS) begin
                    m_mode = 0; m_locked = 0; m_nseed = 0; m_nmatch = 0;
                end
            end else begin
                m_nloss = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else if (in_valid) m_step(in_bit);
        else m_errp = 0;
    end

    // ---------------- per-cycle comparison ----------------------------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("locked",    locked,    m_locked);
            chk("err_pulse", err_pulse, m_errp);
            chk("err_count", err_count, ecnt(m_errc));
            chk("bit_count", bit_count, ecnt(m_bitc));
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic send(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            src_next(b);
            send(1'b1, b);
        end
    endtask

    task automatic send_flip();
        logic b;
        src_next(b);
        send(1'b1, ~b);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_lock_after_30();
        send_clean(29);
        chk("no_lock_at_29", locked, 0);
        send_clean(1);
        chk("lock_at_30", locked, 1);
    endtask

    // ---------------- test sequence -----------------------------------------
    initial begin
        logic b;
        int burst;
        src_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_locked",    locked,    0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_bit_count", bit_count, 0);
        rst = 1'b0;

        // clean stream: lock, then two full periods without error
        expect_lock_after_30();
        send_clean(2046);
        chk("clean_err_count", err_count, 0);
        chk("clean_bit_count", bit_count, ecnt(2046));
        chk("clean_locked",    locked,    1);

        // single corrupted bit
        send_flip();
        chk("flip1_err_pulse", err_pulse, 1);
        chk("flip1_err_count", err_count, ecnt(1));
        chk("flip1_locked",    locked,    1);
        send_clean(1);
        chk("flip1_pulse_end", err_pulse, 0);
        send_clean(100);
        chk("flip1_after",     err_count, ecnt(1));
        chk("flip1_still_lck", locked,    1);

        // four consecutive corrupted bits drop lock on the fourth
        for (int i = 0; i < 3; i++) begin
            send_flip();
            chk("burst_hold_lock", locked, 1);
        end
        send_flip();
        chk("burst_lock_lost", locked,    0);
        chk("burst_err_pulse", err_pulse, 1);
        chk("burst_err_count", err_count, ecnt(5));
        expect_lock_after_30();
        chk("burst_relock_ec", err_count, ecnt(5));

        // async reset while locked with err_count = 3
        pulse_reset();
        expect_lock_after_30();
        for (int i = 0; i < 3; i++) begin
            send_flip();
            send_clean(1);
        end
        chk("pre_rst_err_count", err_count, ecnt(3));
        #2 rst = 1'b1;
        #1;
        chk("arst_locked",    locked,    0);
        chk("arst_err_pulse", err_pulse, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_bit_count", bit_count, 0);
        @(negedge clk);
        rst = 1'b0;
        expect_lock_after_30();

        // 50% in_valid duty: invalid cycles carry garbage and must be ignored
        pulse_reset();
        for (int i = 1; i <= 30; i++) begin
            send_clean(1);
            if (i == 29) chk("duty_no_lock_29", locked, 0);
            if (i == 30) chk("duty_lock_30",    locked, 1);
            send(1'b0, 1'($urandom_range(0, 1)));
            chk("duty_idle_pulse", err_pulse, 0);
        end

        // stuck-at-0 source never leaves seeding; a clean stream then locks in 30
        pulse_reset();
        for (int i = 0; i < 200; i++) send(1'b1, 1'b0);
        chk("zeros_no_lock", locked, 0);
        expect_lock_after_30();

        // stuck-at-1 source never locks
        pulse_reset();
        for (int i = 0; i < 200; i++) send(1'b1, 1'b1);
        chk("ones_no_lock", locked, 0);

        // randomized valid pattern, sparse bit errors and occasional error bursts
        pulse_reset();
        burst = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send(1'b0, 1'($urandom_range(0, 1)));
            end else begin
                src_next(b);
                if (burst == 0 && $urandom_range(0, 399) == 0) burst = $urandom_range(2, 6);
                if (burst > 0) begin
                    burst--;
                    b = ~b;
                end else if ($urandom_range(0, 59) == 0) begin
                    b = ~b;
                end
                send(1'b1, b);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Receiving end of the 10-bit pseudo-random bit stream (polynomial x^10 + x^3 + 1, period 1023) produced by the game's random-bit source. It consumes one serial bit per qualified cycle and synchronises to the sequence. It then declares lock and flags every bit that deviates from the predicted sequence. It sits beside the random source as a built-in self-test: the referee logic reads `locked` and `err_count` to confirm the random generator is alive and not stuck.

## Interface
Parameters:
- LOCK_CNT, 20, consecutive correct predictions required to declare lock (1..255)
- LOSS_CNT, 4, consecutive mispredictions in LOCKED that drop lock (1..15)
- CNT_W, 16, width of err_count and bit_count

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_bit  in  1  received stream bit
- in_valid  in  1  in_bit is sampled on this rising edge when high
- locked  out  1  checker synchronised to the sequence
- err_pulse  out  1  one-cycle pulse, the last valid bit mismatched while LOCKED
- err_count  out  CNT_W  saturating count of mismatches while LOCKED
- bit_count  out  CNT_W  saturating count of valid bits checked while LOCKED

## Operation
- Sequence rule: x[n] = x[n-7] XOR x[n-10]. The 10-bit history register h holds the last 10 bits, with h[0] as the newest. The prediction p = h[6] XOR h[9].
- Cycles with in_valid low change no state, and all outputs hold except err_pulse, which goes to 0.
- SEED:
  - Shift in_bit into h.
  - A 4-bit seed counter counts 0..9.
  - After the 10th valid bit, go to VERIFY if h (including that bit) is non-zero.
  - If h is all zero (illegal LFSR state, stuck-at-0 source), restart the seed counter and stay in SEED.
- VERIFY:
  - Shift in_bit into h (self-synchronising).
  - If in_bit == p, increment the match counter.
  - Otherwise clear the match counter and stay in VERIFY.
  - When the match counter reaches LOCK_CNT, go to LOCKED and clear the loss counter.
- LOCKED:
  - Shift p, not in_bit, into h (flywheel), so that a single corrupted bit produces exactly one mismatch.
  - bit_count is incremented on every valid bit.
  - On a mismatch: assert err_pulse, increment err_count and the loss counter.
  - On a match: clear the loss counter.
  - When the loss counter reaches LOSS_CNT, go to SEED, clear the seed and match counters, and deassert locked. err_count and bit_count are kept.
- Counters saturate at all-ones and never wrap.
- err_count and bit_count clear only on rst.

## Timing
- Reset values: state SEED; h, all counters, locked, err_pulse, err_count and bit_count are all 0.
- Every output is registered and reflects the valid bit sampled on the previous edge. Latency is 1 cycle.
- locked rises on the edge that samples the (10 + LOCK_CNT)-th consecutive good valid bit. It is visible in the following cycle.
- On a mismatch in LOCKED:
  - err_pulse and err_count update on the same edge.
  - On the LOSS_CNT-th consecutive mismatch, locked falls on that same edge and err_pulse is also asserted.
- rst asserted mid-operation returns everything to the reset values immediately, independent of clk.

## Configuration
- PRBS_CHK_ERRCNT_EN:
  - Defined: err_count and bit_count are implemented as described.
  - Undefined: both counters are removed and both outputs are tied to 0. locked and err_pulse behave identically in both builds.

## Structure
- Shared package prbs_pkg:
  - state enum (SEED, VERIFY, LOCKED)
  - PRBS_LEN = 10, TAP_A = 7, TAP_B = 10
  - PRBS_PERIOD = 1023
- One sub-module: prbs_sat_counter (CNT_W-wide, increment enable, saturating). It is instantiated twice under PRBS_CHK_ERRCNT_EN.

## Test plan
- Random source (reset seed 1) feeds in_bit with in_valid = 1 every cycle:
  - locked = 1 in the cycle after the 30th bit.
  - Over the next 2046 bits, err_count stays 0 and bit_count = 2046.
- While LOCKED, invert one bit:
  - err_pulse is high for exactly 1 cycle and err_count = 1.
  - locked stays 1.
  - The following bits produce no further errors.
- While LOCKED, invert 4 consecutive bits:
  - err_count = 4 and locked falls with the 4th bit.
  - After 30 further clean bits, locked = 1 again and err_count still equals 4.
- in_bit constant 0 for 200 cycles: locked stays 0 and the state never leaves SEED. Constant 1 for 200 cycles also never locks.
- Toggle in_valid at 50% duty with the clean stream:
  - Lock occurs after 30 valid bits.
  - Outputs hold during invalid cycles and err_pulse = 0 in those cycles.
- Assert rst for 1 cycle while LOCKED with err_count = 3: all outputs are 0 immediately, and relock occurs after 30 valid bits.
